// File: rtl/bias_loader.sv
// Run-time writable bias table, filled by a byte-serial valid/ready stream.
// Define BIAS_LOADER_CHECKSUM_EN to add a trailing checksum byte and the checksum_err output.
module bias_loader #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic [7:0]                   ra1,
    output logic [WIDTH-1:0]             rd1,
    output logic [$clog2(DEPTH+1)-1:0]   wr_count,
    output logic                         load_done
`ifdef BIAS_LOADER_CHECKSUM_EN
    ,
    output logic                         checksum_err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {LOAD_HI, LOAD_LO, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_count_q, wr_count_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [WIDTH-1:0]  rf_q [DEPTH];
    logic [WIDTH-1:0]  rf_d [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              xfer;
`ifdef BIAS_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign xfer   = in_valid && in_ready;
    assign wr_idx = wr_count_q[AW-1:0];
    assign rd_idx = ra1[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD_HI;
            wr_count_q <= '0;
            hi_byte_q  <= '0;
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            hi_byte_q  <= hi_byte_d;
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= rf_d[i];
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    // start overrides any transfer; in_ready is already low in a start cycle.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        hi_byte_d  = hi_byte_q;
        for (int i = 0; i < DEPTH; i++) rf_d[i] = rf_q[i];
`ifdef BIAS_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        if (start) begin
            state_d    = LOAD_HI;
            wr_count_d = '0;
            hi_byte_d  = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_d      = '0;
            err_d      = 1'b0;
`endif
        end else if (xfer) begin
            case (state_q)
                LOAD_HI: begin
                    hi_byte_d = in_data;
                    state_d   = LOAD_LO;
`ifdef BIAS_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + in_data;
`endif
                end
                LOAD_LO: begin
                    rf_d[wr_idx] = WIDTH'({hi_byte_q, in_data});
                    wr_count_d   = wr_count_q + 1'b1;
`ifdef BIAS_LOADER_CHECKSUM_EN
                    sum_d        = sum_q + in_data;
                    state_d      = (wr_count_q == CW'(DEPTH - 1)) ? CHECK : LOAD_HI;
`else
                    state_d      = (wr_count_q == CW'(DEPTH - 1)) ? DONE : LOAD_HI;
`endif
                end
                CHECK: begin
`ifdef BIAS_LOADER_CHECKSUM_EN
                    err_d   = (in_data != sum_q);
`endif
                    state_d = DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != DONE) && !start && !reset;
        load_done = (state_q == DONE);
        wr_count  = wr_count_q;
        rd1       = (32'(ra1) < DEPTH) ? rf_q[rd_idx] : '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
        checksum_err = err_q;
`endif
    end

endmodule

// File: tb/tb_bias_loader.sv
// Scoreboard bench for bias_loader: stimulus pushes expectations, a negedge monitor pops and compares.
// Define BIAS_LOADER_CHECKSUM_EN to also exercise the checksum byte.
module tb_bias_loader;

    localparam int DEPTH = 15;

    localparam int F_RD1       = 0;
    localparam int F_WR_COUNT  = 1;
    localparam int F_LOAD_DONE = 2;
    localparam int F_IN_READY  = 3;
    localparam int F_CHK_ERR   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  ra1;
    logic [15:0] rd1;
    logic [3:0]  wr_count;
    logic        load_done;
`ifdef BIAS_LOADER_CHECKSUM_EN
    logic        checksum_err;
`endif

    typedef struct {
        string       name;
        int          field;
        logic [31:0] expected;
    } exp_t;

    exp_t sbQueue[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    bias_loader #(.DEPTH(DEPTH), .WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ra1       (ra1),
        .rd1       (rd1),
        .wr_count  (wr_count),
        .load_done (load_done)
`ifdef BIAS_LOADER_CHECKSUM_EN
        ,
        .checksum_err (checksum_err)
`endif
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Monitor: on every falling edge, drain pending expectations against the settled outputs.
    always @(negedge clk) begin
        while (sbQueue.size() > 0) begin
            exp_t        e;
            logic [31:0] actual;
            e = sbQueue.pop_front();
            case (e.field)
                F_RD1:       actual = {16'b0, rd1};
                F_WR_COUNT:  actual = {28'b0, wr_count};
                F_LOAD_DONE: actual = {31'b0, load_done};
                F_IN_READY:  actual = {31'b0, in_ready};
`ifdef BIAS_LOADER_CHECKSUM_EN
                F_CHK_ERR:   actual = {31'b0, checksum_err};
`endif
                default:     actual = 32'hDEAD_BEEF;
            endcase
            nCompared++;
            if (actual !== e.expected) begin
                nMismatched++;
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, actual, e.expected);
            end
        end
    end

    // Advance one cycle, landing just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation for the monitor to check at the next falling edge.
    task automatic checkOutput(input string name, input int field, input int expected);
        exp_t e;
        e.name     = name;
        e.field    = field;
        e.expected = 32'(expected);
        sbQueue.push_back(e);
    endtask

    // Drive a read address, expect a table value, and spend one cycle.
    task automatic checkRead(input int addr, input int expected);
        ra1 = 8'(addr);
        checkOutput($sformatf("rd1[%0d]", addr), F_RD1, expected);
        step();
    endtask

    // Offer one byte and hold it until it transfers, bounded by a cycle budget.
    task automatic applyStimulus(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL handshake byte 0x%02h: in_ready stayed 0, expected 1", b);
    endtask

    // Send one bias word, high byte first.
    task automatic sendWord(input logic [15:0] w);
        applyStimulus(w[15:8]);
        applyStimulus(w[7:0]);
    endtask

    // One-cycle start pulse, optionally with a byte offered in the same cycle.
    task automatic pulseStart(input bit withValid);
        start    = 1'b1;
        in_valid = withValid;
        in_data  = 8'hCD;
        checkOutput("in_ready_during_start", F_IN_READY, 0);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Close out a full load: checksum byte when enabled, then done-state checks.
    task automatic finishLoad(input logic [7:0] sum, input string tag);
`ifdef BIAS_LOADER_CHECKSUM_EN
        checkOutput({tag, "_ready_in_check"}, F_IN_READY, 1);
        checkOutput({tag, "_not_done_in_check"}, F_LOAD_DONE, 0);
        step();
        applyStimulus(sum);
        checkOutput({tag, "_checksum_err"}, F_CHK_ERR, 0);
`else
        if (sum == 8'h00) $display("[TB] note: zero checksum for %s", tag);
`endif
        checkOutput({tag, "_load_done"}, F_LOAD_DONE, 1);
        checkOutput({tag, "_wr_count"}, F_WR_COUNT, DEPTH);
        checkOutput({tag, "_in_ready_done"}, F_IN_READY, 0);
        step();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ra1      = 8'h00;
        step();
        step();

        // Reset state.
        checkOutput("reset_in_ready", F_IN_READY, 0);
        checkOutput("reset_wr_count", F_WR_COUNT, 0);
        checkOutput("reset_load_done", F_LOAD_DONE, 0);
        checkOutput("reset_rd1", F_RD1, 0);
        step();
        reset = 1'b0;
        checkOutput("in_ready_after_release", F_IN_READY, 1);
        step();

        // Unstalled load of words 1..15.
        for (int k = 0; k < DEPTH; k++) sendWord(16'(k + 1));
        finishLoad(8'h78, "load1");
        for (int i = 0; i < DEPTH; i++) checkRead(i, i + 1);
        checkRead(15, 0);
        checkRead(200, 0);
        checkRead(3, 4);

        // Same stream with a stall cycle after every byte.
        pulseStart(1'b0);
        checkOutput("restart_load_done", F_LOAD_DONE, 0);
        checkOutput("restart_wr_count", F_WR_COUNT, 0);
        step();
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(8'h00);
            checkOutput($sformatf("stall_hi_ready_%0d", k), F_IN_READY, 1);
            step();
            applyStimulus(8'(k + 1));
            checkOutput($sformatf("stall_wr_count_%0d", k), F_WR_COUNT, k + 1);
            if (k < DEPTH - 1)
                checkOutput($sformatf("stall_lo_ready_%0d", k), F_IN_READY, 1);
            step();
        end
        finishLoad(8'h78, "load2");
        for (int i = 0; i < DEPTH; i++) checkRead(i, i + 1);

        // A held high byte is discarded by start; a start cycle with valid accepts nothing.
        pulseStart(1'b0);
        step();
        applyStimulus(8'hAB);
        checkOutput("hi_only_wr_count", F_WR_COUNT, 0);
        step();
        pulseStart(1'b1);
        checkOutput("after_start_valid_wr_count", F_WR_COUNT, 0);
        checkOutput("after_start_valid_ready", F_IN_READY, 1);
        step();
        for (int k = 0; k < DEPTH; k++) sendWord(16'h1234);
        finishLoad(8'h1A, "load3");
        for (int i = 0; i < DEPTH; i++) checkRead(i, 16'h1234);

        // Reset mid-load clears everything including the table.
        pulseStart(1'b0);
        step();
        for (int k = 0; k < 7; k++) sendWord(16'(16'h0100 + k));
        checkOutput("partial_wr_count", F_WR_COUNT, 7);
        step();
        checkRead(0, 16'h0100);
        checkRead(7, 16'h1234);
        applyStimulus(8'h99);
        reset = 1'b1;
        checkOutput("midreset_in_ready", F_IN_READY, 0);
        checkOutput("midreset_wr_count", F_WR_COUNT, 0);
        checkOutput("midreset_load_done", F_LOAD_DONE, 0);
        step();
        for (int i = 0; i < DEPTH; i++) checkRead(i, 0);
        reset = 1'b0;
        checkOutput("post_reset_ready", F_IN_READY, 1);
        step();

`ifdef BIAS_LOADER_CHECKSUM_EN
        // Checksum good, then bad, then cleared by start.
        for (int k = 0; k < 2 * DEPTH; k++) applyStimulus(8'h01);
        applyStimulus(8'h1E);
        checkOutput("cks_good_err", F_CHK_ERR, 0);
        checkOutput("cks_good_done", F_LOAD_DONE, 1);
        step();
        pulseStart(1'b0);
        for (int k = 0; k < 2 * DEPTH; k++) applyStimulus(8'h01);
        applyStimulus(8'h1F);
        checkOutput("cks_bad_err", F_CHK_ERR, 1);
        checkOutput("cks_bad_done", F_LOAD_DONE, 1);
        step();
        pulseStart(1'b0);
        checkOutput("cks_cleared_err", F_CHK_ERR, 0);
        checkOutput("cks_cleared_done", F_LOAD_DONE, 0);
        step();
`endif

        for (int i = 0; i < 10 && sbQueue.size() > 0; i++) step();
        if (sbQueue.size() > 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sbQueue.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
